// File: rtl/ws2812_pixel_rx.sv
// ws2812_pixel_rx: decodes a WS2812 pulse-width stream, captures the first pixel after a gap and forwards the rest on dout.
module ws2812_pixel_rx #(
  parameter int T1_MIN       = 15,
  parameter int MAX_HIGH     = 50,
  parameter int RESET_CYCLES = 1250,
  parameter int NB_BITS      = 24
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               din,
  output logic               dout,
  output logic [NB_BITS-1:0] pixel_data,
  output logic               pixel_valid,
  output logic               frame_end,
  output logic               rx_error
);
  localparam int HW = $clog2(MAX_HIGH + 2);
  localparam int LW = $clog2(RESET_CYCLES + 1);
  localparam int BW = $clog2(NB_BITS);
  typedef enum logic {RECV, FORWARD} state_t;
  state_t state, state_n;
  logic din_m, din_s, din_d;
  logic [HW-1:0] high_cnt;
  logic [LW-1:0] low_cnt;
  logic [BW-1:0] bit_cnt, bit_cnt_n;
  logic [NB_BITS-1:0] shift_reg, shift_n;
  logic rise, fall, gap, perr, bit_v, accept, last;
  always_comb begin
    rise      = din_s & ~din_d;
    fall      = ~din_s & din_d;
    gap       = ~din_s && low_cnt == LW'(RESET_CYCLES - 1);
    perr      = fall && high_cnt > HW'(MAX_HIGH);
    bit_v     = high_cnt >= HW'(T1_MIN);
    accept    = fall && !perr && state == RECV;
    last      = bit_cnt == BW'(NB_BITS - 1);
    shift_n   = accept ? {shift_reg[NB_BITS-2:0], bit_v} : shift_reg;
    state_n   = gap ? RECV : (accept && last) ? FORWARD : state;
    bit_cnt_n = (gap || (accept && last)) ? '0 : accept ? bit_cnt + 1'b1 : bit_cnt;
  end
  always_ff @(posedge wb_clk_i)
    state <= wb_rst_i ? RECV : state_n;
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      {din_d, din_s, din_m} <= '0;
      high_cnt    <= '0;
      low_cnt     <= '0;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      pixel_data  <= '0;
      pixel_valid <= 1'b0;
      frame_end   <= 1'b0;
      rx_error    <= 1'b0;
      dout        <= 1'b0;
    end else begin
      {din_d, din_s, din_m} <= {din_s, din_m, din};
      // high_cnt counts the first high cycle on the rise so it equals the pulse width at the fall
      high_cnt    <= rise ? HW'(1) : (din_s && high_cnt <= HW'(MAX_HIGH)) ? high_cnt + 1'b1 : high_cnt;
      low_cnt     <= rise ? '0 : (!din_s && low_cnt < LW'(RESET_CYCLES)) ? low_cnt + 1'b1 : low_cnt;
      bit_cnt     <= bit_cnt_n;
      shift_reg   <= shift_n;
      pixel_valid <= accept && last;
      if (accept && last) pixel_data <= shift_n;
      frame_end   <= gap;
      rx_error    <= perr || (gap && bit_cnt != '0);
      dout        <= state == FORWARD && din_s;
    end
  end
endmodule
